dm_arbiter: RTL and testbench

Two-port arbiter that shares the data-memory/IO block between the CPU load/store stage (port 0) and a DMA/program loader (port 1). It sits directly in front of the memory/IO block. It issues at most one access per cycle and alternates fairly between the two requesters using round-robin. It registers read data back to the requester and blocks port 1 from the memory-mapped IO window (LEDs/switches, address bit 12 set).

---
 rtl/dm_arbiter_if.sv | 38 +++
 rtl/dm_arbiter.sv | 124 ++++++++++++
 tb/tb_dm_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_arbiter_if.sv
// Bus bundle between the two requesters (CPU load/store, DMA loader) and the
// data-memory/IO block, with the arbiter sitting in the middle as the slave.
interface dm_arbiter_if #(
  parameter int AW = 64,
  parameter int DW = 64
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic          err1;
  logic [AW-1:0] dm_direccion;
  logic [DW-1:0] dm_dataWrite;
  logic          dm_memWr;
  logic [DW-1:0] dm_dataRead;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, dm_dataRead,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err1,
    output dm_direccion, dm_dataWrite, dm_memWr
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, dm_dataRead,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err1,
    input  dm_direccion, dm_dataWrite, dm_memWr
  );
endinterface

// File: rtl/dm_arbiter.sv
// Round-robin two-port arbiter in front of the data-memory/IO block; port 1
// (DMA/loader) is fenced out of the memory-mapped IO window.
module dm_arbiter #(
  parameter int AW     = 64,
  parameter int DW     = 64,
  parameter int IO_BIT = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  dm_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          rr_last_q, rr_last_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic          err1_q, err1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  logic [AW-1:0] addr_sel;
  logic [DW-1:0] wdata_sel;
  logic          mem_wr;
  logic          io_hit;

  assign io_hit = bus.addr1[IO_BIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      err1_q    <= err1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  // The port just served never goes straight back: its still-high req is
  // only seen again after a cycle away from its grant state.
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    addr_sel  = '0;
    wdata_sel = '0;
    mem_wr    = 1'b0;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    err1_d    = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;

    case (state_q)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
          state_d = rr_last_q ? GNT0 : GNT1;
        end else if (bus.req0) begin
          state_d = GNT0;
        end else if (bus.req1) begin
          state_d = GNT1;
        end
      end

      GNT0: begin
        rr_last_d = 1'b0;
        state_d   = bus.req1 ? GNT1 : IDLE;
        addr_sel  = bus.addr0;
        wdata_sel = bus.wdata0;
        mem_wr    = bus.we0 && bus.req0;
        if (!bus.we0) begin
          rvalid0_d = 1'b1;
          rdata0_d  = bus.dm_dataRead;
        end
      end

      GNT1: begin
        rr_last_d = 1'b1;
        state_d   = bus.req0 ? GNT0 : IDLE;
        addr_sel  = bus.addr1;
        wdata_sel = bus.wdata1;
        mem_wr    = bus.we1 && bus.req1 && !io_hit;
        rvalid1_d = !bus.we1;
        // A refused access returns zero instead of whatever IO would drive.
        if (io_hit) begin
          err1_d   = 1'b1;
          rdata1_d = '0;
        end else if (!bus.we1) begin
          rdata1_d = bus.dm_dataRead;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.gnt0         = (state_q == GNT0);
  assign bus.gnt1         = (state_q == GNT1);
  assign bus.dm_direccion = addr_sel;
  assign bus.dm_dataWrite = wdata_sel;
  assign bus.dm_memWr     = mem_wr;
  assign bus.rvalid0      = rvalid0_q;
  assign bus.rvalid1      = rvalid1_q;
  assign bus.err1         = err1_q;
  assign bus.rdata0       = rdata0_q;
  assign bus.rdata1       = rdata1_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed vector table, hand-written reset/back-to-back
// sequences, then random traffic against an eligibility-based reference model.
module tb_dm_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;

  typedef struct {
    logic        req0;
    logic        we0;
    logic [63:0] addr0;
    logic [63:0] wdata0;
    logic        req1;
    logic        we1;
    logic [63:0] addr1;
    logic [63:0] wdata1;
    logic [63:0] dm_read;
    logic        gnt0;
    logic        gnt1;
    logic        mem_wr;
    logic [63:0] dir;
    logic [63:0] wdata_out;
    logic        rvalid0;
    logic        rvalid1;
    logic        err1;
    logic [63:0] rdata0;
    logic [63:0] rdata1;
  } vec_t;

  localparam logic        L = 1'b0;
  localparam logic        H = 1'b1;
  localparam logic [63:0] Z = 64'h0;

  logic clk;
  logic rst_n;
  int   assert_count = 0;
  int   fail_count   = 0;

  vec_t vec_tab[21];

  // Reference model: grant expected this cycle (-1 none), last port served,
  // and the registered results it will show.
  int          m_grant;
  int          m_last;
  logic        m_rv0, m_rv1, m_err1;
  logic [63:0] m_rd0, m_rd1;

  dm_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dm_arbiter #(.AW(AW), .DW(DW), .IO_BIT(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input string field,
                             input logic [63:0] actual, input logic [63:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s.%s: got %h expected %h", tag, field, actual, expected);
    end
  endtask

  function automatic vec_t zero_vec();
    vec_t v;
    v = '{L, L, Z, Z, L, L, Z, Z, Z, L, L, L, Z, Z, L, L, L, Z, Z};
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    bus.req0        = v.req0;
    bus.we0         = v.we0;
    bus.addr0       = v.addr0;
    bus.wdata0      = v.wdata0;
    bus.req1        = v.req1;
    bus.we1         = v.we1;
    bus.addr1       = v.addr1;
    bus.wdata1      = v.wdata1;
    bus.dm_dataRead = v.dm_read;
  endtask

  task automatic checkVector(input string tag, input vec_t v);
    @(negedge clk);
    checkOutput(tag, "gnt0",      64'(bus.gnt0),     64'(v.gnt0));
    checkOutput(tag, "gnt1",      64'(bus.gnt1),     64'(v.gnt1));
    checkOutput(tag, "memWr",     64'(bus.dm_memWr), 64'(v.mem_wr));
    checkOutput(tag, "direccion", bus.dm_direccion,  v.dir);
    checkOutput(tag, "dataWrite", bus.dm_dataWrite,  v.wdata_out);
    checkOutput(tag, "rvalid0",   64'(bus.rvalid0),  64'(v.rvalid0));
    checkOutput(tag, "rvalid1",   64'(bus.rvalid1),  64'(v.rvalid1));
    checkOutput(tag, "err1",      64'(bus.err1),     64'(v.err1));
    checkOutput(tag, "rdata0",    bus.rdata0,        v.rdata0);
    checkOutput(tag, "rdata1",    bus.rdata1,        v.rdata1);
  endtask

  task automatic doReset();
    vec_t z;
    z = zero_vec();
    @(negedge clk);
    rst_n           = 1'b0;
    bus.req0        = z.req0;
    bus.we0         = z.we0;
    bus.addr0       = z.addr0;
    bus.wdata0      = z.wdata0;
    bus.req1        = z.req1;
    bus.we1         = z.we1;
    bus.addr1       = z.addr1;
    bus.wdata1      = z.wdata1;
    bus.dm_dataRead = z.dm_read;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Expected outputs for the current cycle from the model and this cycle's inputs.
  function automatic vec_t model_expect(input vec_t v);
    vec_t e;
    e = v;
    e.gnt0      = (m_grant == 0);
    e.gnt1      = (m_grant == 1);
    e.mem_wr    = 1'b0;
    e.dir       = Z;
    e.wdata_out = Z;
    if (m_grant == 0) begin
      e.dir       = v.addr0;
      e.wdata_out = v.wdata0;
      e.mem_wr    = v.we0 && v.req0;
    end else if (m_grant == 1) begin
      e.dir       = v.addr1;
      e.wdata_out = v.wdata1;
      e.mem_wr    = v.we1 && v.req1 && !v.addr1[12];
    end
    e.rvalid0 = m_rv0;
    e.rvalid1 = m_rv1;
    e.err1    = m_err1;
    e.rdata0  = m_rd0;
    e.rdata1  = m_rd1;
    return e;
  endfunction

  task automatic model_advance(input vec_t v);
    bit elig0, elig1;
    elig0  = v.req0 && (m_grant != 0);
    elig1  = v.req1 && (m_grant != 1);
    m_rv0  = (m_grant == 0) && !v.we0;
    m_rv1  = (m_grant == 1) && !v.we1;
    m_err1 = (m_grant == 1) && v.addr1[12];
    if (m_rv0) m_rd0 = v.dm_read;
    if (m_err1) m_rd1 = Z;
    else if (m_rv1) m_rd1 = v.dm_read;
    if (m_grant >= 0) m_last = m_grant;
    if (elig0 && elig1) m_grant = (m_last == 0) ? 1 : 0;
    else if (elig0) m_grant = 0;
    else if (elig1) m_grant = 1;
    else m_grant = -1;
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0;

    //             req0 we0 addr0     wdata0    req1 we1 addr1      wdata1   dm_read      | gnt0 gnt1 wr dir        wdata     rv0 rv1 err rdata0       rdata1
    vec_tab[0]  = '{L, L, Z,        Z,        L, L, Z,        Z,        Z,             L, L, L, Z,        Z,        L, L, L, Z,           Z};
    vec_tab[1]  = '{H, L, 64'h10,   Z,        L, L, Z,        Z,        64'hDEAD,      L, L, L, Z,        Z,        L, L, L, Z,           Z};
    vec_tab[2]  = '{H, L, 64'h10,   Z,        L, L, Z,        Z,        64'hDEAD,      H, L, L, 64'h10,   Z,        L, L, L, Z,           Z};
    vec_tab[3]  = '{L, L, Z,        Z,        L, L, Z,        Z,        Z,             L, L, L, Z,        Z,        H, L, L, 64'hDEAD,    Z};
    vec_tab[4]  = '{H, H, 64'h20,   64'hA0,   H, L, 64'h30,   64'hB0,   64'h1234,      L, L, L, Z,        Z,        L, L, L, 64'hDEAD,    Z};
    vec_tab[5]  = '{H, H, 64'h20,   64'hA0,   H, L, 64'h30,   64'hB0,   64'h1234,      L, H, L, 64'h30,   64'hB0,   L, L, L, 64'hDEAD,    Z};
    vec_tab[6]  = '{H, H, 64'h20,   64'hA0,   H, L, 64'h30,   64'hB0,   64'h1234,      H, L, H, 64'h20,   64'hA0,   L, H, L, 64'hDEAD,    64'h1234};
    vec_tab[7]  = '{H, H, 64'h20,   64'hA0,   H, L, 64'h30,   64'hB0,   64'h5678,      L, H, L, 64'h30,   64'hB0,   L, L, L, 64'hDEAD,    64'h1234};
    vec_tab[8]  = '{H, H, 64'h20,   64'hA0,   L, L, Z,        Z,        Z,             H, L, H, 64'h20,   64'hA0,   L, H, L, 64'hDEAD,    64'h5678};
    vec_tab[9]  = '{L, L, Z,        Z,        L, L, Z,        Z,        Z,             L, L, L, Z,        Z,        L, L, L, 64'hDEAD,    64'h5678};
    vec_tab[10] = '{L, L, Z,        Z,        H, H, 64'h1000, 64'hFF,   Z,             L, L, L, Z,        Z,        L, L, L, 64'hDEAD,    64'h5678};
    vec_tab[11] = '{L, L, Z,        Z,        H, H, 64'h1000, 64'hFF,   Z,             L, H, L, 64'h1000, 64'hFF,   L, L, L, 64'hDEAD,    64'h5678};
    vec_tab[12] = '{H, H, 64'h1000, 64'h77,   L, L, Z,        Z,        Z,             L, L, L, Z,        Z,        L, L, H, 64'hDEAD,    Z};
    vec_tab[13] = '{H, H, 64'h1000, 64'h77,   L, L, Z,        Z,        Z,             H, L, H, 64'h1000, 64'h77,   L, L, L, 64'hDEAD,    Z};
    vec_tab[14] = '{L, L, Z,        Z,        L, L, Z,        Z,        Z,             L, L, L, Z,        Z,        L, L, L, 64'hDEAD,    Z};
    vec_tab[15] = '{H, H, 64'h40,   64'h44,   L, L, Z,        Z,        Z,             L, L, L, Z,        Z,        L, L, L, 64'hDEAD,    Z};
    vec_tab[16] = '{L, H, 64'h40,   64'h44,   L, L, Z,        Z,        Z,             H, L, L, 64'h40,   64'h44,   L, L, L, 64'hDEAD,    Z};
    vec_tab[17] = '{L, L, Z,        Z,        L, L, Z,        Z,        Z,             L, L, L, Z,        Z,        L, L, L, 64'hDEAD,    Z};
    vec_tab[18] = '{L, L, Z,        Z,        H, L, 64'h1000, Z,        64'hABCD,      L, L, L, Z,        Z,        L, L, L, 64'hDEAD,    Z};
    vec_tab[19] = '{L, L, Z,        Z,        L, L, 64'h1000, Z,        64'hABCD,      L, H, L, 64'h1000, Z,        L, L, L, 64'hDEAD,    Z};
    vec_tab[20] = '{L, L, Z,        Z,        L, L, Z,        Z,        Z,             L, L, L, Z,        Z,        L, H, H, 64'hDEAD,    Z};

    doReset();
    for (int i = 0; i < 21; i++) begin
      applyStimulus(vec_tab[i]);
      checkVector($sformatf("vec%0d", i), vec_tab[i]);
    end

    // Reset arriving in the middle of a port-0 write must kill the strobe at once.
    v = zero_vec();
    v.req0   = H;
    v.we0    = H;
    v.addr0  = 64'h50;
    v.wdata0 = 64'h55;
    applyStimulus(v);
    applyStimulus(v);
    @(negedge clk);
    checkOutput("rstmid", "memWrBefore", 64'(bus.dm_memWr), 64'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid", "memWr",     64'(bus.dm_memWr), 64'(1'b0));
    checkOutput("rstmid", "gnt0",      64'(bus.gnt0),     64'(1'b0));
    checkOutput("rstmid", "direccion", bus.dm_direccion,  Z);
    checkOutput("rstmid", "rdata0",    bus.rdata0,        Z);
    v = zero_vec();
    bus.req0 = L;
    bus.we0  = L;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(v);
    checkVector("rstpost", v);

    // First tie after reset goes to port 0.
    v = zero_vec();
    v.req0 = H;
    v.req1 = H;
    applyStimulus(v);
    checkVector("tie_idle", zero_vec());
    v = zero_vec();
    applyStimulus(v);
    v.gnt0 = H;
    checkVector("tie_gnt", v);
    applyStimulus(zero_vec());
    v = zero_vec();
    v.rvalid0 = H;
    checkVector("tie_rv", v);

    // A lone requester holding req gets every other cycle.
    applyStimulus(zero_vec());
    for (int i = 0; i < 6; i++) begin
      v = zero_vec();
      v.req1   = H;
      v.we1    = H;
      v.addr1  = 64'h60;
      v.wdata1 = 64'h66;
      applyStimulus(v);
      @(negedge clk);
      checkOutput($sformatf("b2b%0d", i), "gnt1",  64'(bus.gnt1),     64'(i % 2 == 1));
      checkOutput($sformatf("b2b%0d", i), "memWr", 64'(bus.dm_memWr), 64'(i % 2 == 1));
    end
    applyStimulus(zero_vec());

    // Random traffic against the reference model.
    doReset();
    m_grant = -1;
    m_last  = 1;
    m_rv0   = L;
    m_rv1   = L;
    m_err1  = L;
    m_rd0   = Z;
    m_rd1   = Z;
    for (int i = 0; i < 400; i++) begin
      v = zero_vec();
      v.req0    = ($urandom_range(0, 9) < 6);
      v.req1    = ($urandom_range(0, 9) < 6);
      v.we0     = $urandom_range(0, 1);
      v.we1     = $urandom_range(0, 1);
      v.addr0   = {$urandom, $urandom};
      v.addr1   = {$urandom, $urandom};
      v.wdata0  = {$urandom, $urandom};
      v.wdata1  = {$urandom, $urandom};
      v.dm_read = {$urandom, $urandom};
      v = model_expect(v);
      applyStimulus(v);
      checkVector($sformatf("rnd%0d", i), v);
      model_advance(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end
endmodule
